// File: rtl/uart_arb_pkg.sv
// Shared types and default sizing for the uart_tx byte-stream arbiter.
package uart_arb_pkg;

    localparam int DEF_NREQ         = 4;
    localparam int DEF_LOCK_TIMEOUT = 50_000;
    localparam int DEF_ACK_TIMEOUT  = 4;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_LOW,
        WAIT_HIGH
    } arb_state_e;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } arb_byte_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin pick: first set bit of req at or after start, wrapping.
module rr_picker #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_id,
    output logic          any
);

    logic [IW:0]   sum;
    logic [IW-1:0] idx;

    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        any    = 1'b0;
        sum    = '0;
        idx    = '0;
        for (int off = 0; off < N; off++) begin
            sum = {1'b0, start} + (IW+1)'(off);
            if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
            idx = sum[IW-1:0];
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx among NREQ byte-stream requesters with round-robin and packet locking.
// Build option: define UART_ARB_HIPRI_EN to give requester 0 priority whenever no lock is held.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter  int NREQ         = DEF_NREQ,
    parameter  int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
    parameter  int ACK_TIMEOUT  = DEF_ACK_TIMEOUT,
    localparam int IDW          = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*8-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [IDW-1:0]    grant_id,
    output logic              busy,
    output logic              err_ack,
    output logic              lock_abort
);

    localparam int LCW = $clog2(LOCK_TIMEOUT + 1);
    localparam int ACW = $clog2(ACK_TIMEOUT + 1);

    arb_state_e     state, state_n;
    arb_byte_t      hold;
    logic [IDW-1:0] last_grant, lock_id, start, rr_id, win_id;
    logic           locked;
    logic [LCW-1:0] lock_cnt;
    logic [ACW-1:0] ack_cnt;
    logic [NREQ-1:0] elig, rr_gnt;
    logic           rr_any, hipri;
    logic           accept, ack_inc, ack_exp, lock_inc, lock_exp, pkt_done, lock_set;

    assign start = (last_grant == IDW'(NREQ - 1)) ? '0 : last_grant + IDW'(1);
    assign elig  = locked ? (req_valid & (NREQ'(1) << lock_id)) : req_valid;

`ifdef UART_ARB_HIPRI_EN
    assign hipri = !locked && req_valid[0];
`else
    assign hipri = 1'b0;
`endif

    rr_picker #(.N(NREQ)) u_pick (
        .req    (elig),
        .start  (start),
        .gnt    (rr_gnt),
        .gnt_id (rr_id),
        .any    (rr_any)
    );

    always_comb begin
        state_n   = state;
        req_ready = '0;
        win_id    = rr_id;
        accept    = 1'b0;
        ack_inc   = 1'b0;
        ack_exp   = 1'b0;
        lock_inc  = 1'b0;
        lock_exp  = 1'b0;
        pkt_done  = 1'b0;
        lock_set  = 1'b0;
        case (state)
            IDLE: begin
                // Locked owner has gone quiet: age the lock toward forced release.
                if (locked && !req_valid[lock_id]) begin
                    if (lock_cnt == LCW'(LOCK_TIMEOUT - 1)) lock_exp = 1'b1;
                    else                                    lock_inc = 1'b1;
                end
                if (tx_ready && (hipri || rr_any)) begin
                    accept    = 1'b1;
                    win_id    = hipri ? '0 : rr_id;
                    req_ready = hipri ? NREQ'(1) : rr_gnt;
                    state_n   = ISSUE;
                end
            end
            ISSUE: state_n = WAIT_LOW;
            WAIT_LOW: begin
                if (!tx_ready) begin
                    state_n = WAIT_HIGH;
                end else if (ack_cnt == ACW'(ACK_TIMEOUT - 1)) begin
                    ack_exp = 1'b1;
                    state_n = IDLE;
                end else begin
                    ack_inc = 1'b1;
                end
            end
            WAIT_HIGH: begin
                if (tx_ready) begin
                    state_n = IDLE;
                    if (hold.last) pkt_done = 1'b1;
                    else           lock_set = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            hold       <= '0;
            grant_id   <= '0;
            last_grant <= IDW'(NREQ - 1);
            locked     <= 1'b0;
            lock_id    <= '0;
            lock_cnt   <= '0;
            ack_cnt    <= '0;
        end else begin
            state   <= state_n;
            ack_cnt <= ack_inc ? ack_cnt + ACW'(1) : '0;
            if (accept) begin
                hold     <= '{data: req_data[{win_id, 3'b000} +: 8], last: req_last[win_id]};
                grant_id <= win_id;
                lock_cnt <= '0;
            end else if (lock_inc) begin
                lock_cnt <= lock_cnt + LCW'(1);
            end
            if (lock_exp) begin
                locked     <= 1'b0;
                last_grant <= lock_id;
                lock_cnt   <= '0;
            end
            if (ack_exp || pkt_done) begin
                locked     <= 1'b0;
                last_grant <= grant_id;
            end
            if (lock_set) begin
                locked  <= 1'b1;
                lock_id <= grant_id;
            end
        end
    end

    assign tx_valid   = (state == ISSUE);
    assign tx_data    = hold.data;
    assign busy       = (state != IDLE) || locked;
    assign err_ack    = ack_exp;
    assign lock_abort = lock_exp;

endmodule
